// File: rtl/delta3_vec_seq_if.sv
// ---------------------------------------------------------------------------
// delta3_vec_seq_if
//   Bus bundle between the layer-3 forward path (operand producer / result
//   consumer) and the delta3_vec_seq error-term block.
//
//   start_i   request a new pass (sampled by the block only while idle)
//   a3_i      layer-3 outputs, channel k at [k*DATA_W +: DATA_W]
//   t_i       supervisor targets, same packing
//   dadz3_i   sigmoid derivative, same packing
//   busy_o    high while the block is walking the channels
//   done_o    one-cycle pulse: delta3_o holds a complete result vector
//   delta3_o  registered results, same packing
//
//   master : the producer/consumer side (drives operands and start)
//   slave  : the delta3_vec_seq block
// ---------------------------------------------------------------------------
interface delta3_vec_seq_if #(
  parameter int N_OUT  = 3,
  parameter int DATA_W = 16
);
  logic                      start_i;
  logic [N_OUT*DATA_W-1:0]   a3_i;
  logic [N_OUT*DATA_W-1:0]   t_i;
  logic [N_OUT*DATA_W-1:0]   dadz3_i;
  logic                      busy_o;
  logic                      done_o;
  logic [N_OUT*DATA_W-1:0]   delta3_o;

  modport master (
    output start_i, a3_i, t_i, dadz3_i,
    input  busy_o, done_o, delta3_o
  );

  modport slave (
    input  start_i, a3_i, t_i, dadz3_i,
    output busy_o, done_o, delta3_o
  );
endinterface

// File: rtl/delta3_vec_seq.sv
// ---------------------------------------------------------------------------
// delta3_vec_seq
//   Output-layer error term of the backprop network:
//     delta3[k] = (a3[k] - t[k]) * dadz3[k],  k = 0 .. N_OUT-1
//   One channel per clock through a single shared multiplier. Operands are
//   captured into shadow registers when a pass starts, so the upstream buses
//   are free to move while the block is busy.
//
//   Ports:
//     clk  in  clock, all state on the rising edge
//     res  in  synchronous active-high reset
//     bus  delta3_vec_seq_if.slave (start_i, a3_i, t_i, dadz3_i in;
//          busy_o, done_o, delta3_o out)
//
//   Timing: start_i accepted at edge E0 in IDLE; channel k is written at edge
//   E0+1+k; done_o is high for the single cycle after edge E0+N_OUT.
//
//   Build option: define DELTA3_SAT_EN to clamp out-of-range results to the
//   signed DATA_W range; otherwise results wrap modulo 2^DATA_W.
// ---------------------------------------------------------------------------
module delta3_vec_seq #(
  parameter int N_OUT  = 3,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic               clk,
  input  logic               res,
  delta3_vec_seq_if.slave    bus
);

  localparam int NW    = N_OUT * DATA_W;
  localparam int PW    = 2 * DATA_W + 1;
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

`ifdef DELTA3_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX =
    $signed({{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN =
    $signed({{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}});
`endif

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;
  logic               wr_en;

  logic [NW-1:0]      a3_sh, t_sh, d_sh;
  logic [NW-1:0]      delta3_p1;

  logic signed [DATA_W-1:0] a_p0, t_p0, d_p0;
  logic signed [DATA_W-1:0] delta_p0;

  // Reduce the shifted product to DATA_W bits: clamp or plain wrap.
  function automatic logic signed [DATA_W-1:0] fit_result(
    input logic signed [PW-1:0] v
  );
`ifdef DELTA3_SAT_EN
    if (v > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Difference is one bit wider than the operands so it can never overflow;
  // the product is kept at full width and shifted arithmetically, which
  // truncates toward -inf.
  function automatic logic signed [DATA_W-1:0] delta_term(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] t,
    input logic signed [DATA_W-1:0] d
  );
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shr;
    diff = $signed({a[DATA_W-1], a}) - $signed({t[DATA_W-1], t});
    prod = $signed({{DATA_W{diff[DATA_W]}}, diff})
         * $signed({{(DATA_W+1){d[DATA_W-1]}}, d});
    shr  = prod >>> FRAC_W;
    return fit_result(shr);
  endfunction

  // FSM next-state and control
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          load    = 1'b1;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        wr_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Stage p0: select the current channel from the shadows and form its term
  assign a_p0     = $signed(a3_sh[idx_q*DATA_W +: DATA_W]);
  assign t_p0     = $signed(t_sh[idx_q*DATA_W +: DATA_W]);
  assign d_p0     = $signed(d_sh[idx_q*DATA_W +: DATA_W]);
  assign delta_p0 = delta_term(a_p0, t_p0, d_p0);

  // Stage p1: result slots, shadows and control state
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a3_sh     <= '0;
      t_sh      <= '0;
      d_sh      <= '0;
      delta3_p1 <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        a3_sh <= bus.a3_i;
        t_sh  <= bus.t_i;
        d_sh  <= bus.dadz3_i;
      end
      if (wr_en)
        delta3_p1[idx_q*DATA_W +: DATA_W] <= delta_p0;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.delta3_o = delta3_p1;

endmodule
